mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have a single clock, clk; reset is synchronous and active-high, port reset.
REQ-002 SHALL provide these ports: clk  in  1  rising-edge clock.
REQ-003 SHALL provide: reset  in  1  synchronous active-high reset.
REQ-004 SHALL provide: en  in  1  capture enable; 0 = stall, hold contents.
REQ-005 SHALL provide: flush  in  1  capture a bubble (all-zero) instead of inputs.
REQ-006 SHALL provide: Instr_M  in  32  instruction leaving the memory stage.
REQ-007 SHALL provide: pc_add_8_M  in  32  link value for jal/jalr.
REQ-008 SHALL provide: ALUResult_M  in  32  ALU result / memory address.
REQ-009 SHALL provide: DM_data_M  in  32  load data, already width-extended.
REQ-010 SHALL provide: HiLo_M  in  32  mfhi/mflo result.
REQ-011 SHALL provide: Instr_W  out  32  registered instruction.
REQ-012 SHALL provide: RegWrite_W  out  1  register-file write enable.
REQ-013 SHALL provide: RegAddr_W  out  5  destination register.
REQ-014 SHALL provide: RegData_W  out  32  write-back data; also the W-stage forwarding source.
REQ-015 SHALL provide: retire_cnt  out  32  count of retired non-nop instructions.

Function
REQ-016 SHALL, on a rising clk edge, apply priority reset > flush > en; when none is asserted, all registered state SHALL hold.
REQ-017 SHALL, with en=1 and flush=0, capture Instr_M, pc_add_8_M, ALUResult_M, DM_data_M and HiLo_M; the W outputs reflect them one cycle later (latency 1).
REQ-018 SHALL, on flush=1, load all pipeline registers with 0, i.e. a nop, regardless of en.
REQ-019 SHALL derive RegWrite_W, RegAddr_W and RegData_W combinationally from registered state only.
REQ-020 SHALL select source ALU for: R-type addu/add/subu/sub/and/or/xor/nor/slt/sltu/sll/srl/sra/sllv/srlv/srav; and ori/xori/andi/slti/sltiu/addi/addiu/lui.
REQ-021 SHALL select source MEM (DM data) for lw/lb/lbu/lh/lhu.
REQ-022 SHALL select source PC8 for jal and jalr.
REQ-023 SHALL select source HILO for mfhi and mflo.
REQ-024 SHALL select no write for: stores, branches, j, jr, mult/multu/div/divu, mthi/mtlo, nop, and any undecoded opcode or funct.
REQ-025 SHALL set the destination as follows: R-type (including jalr) -> Instr[15:11]; I-type and loads -> Instr[20:16]; jal -> 31.
REQ-026 SHALL force RegWrite_W=0 when the destination is 0 or the source is none; in that case RegAddr_W=0 and RegData_W=0.
REQ-027 SHALL treat sll with Instr=0 as a nop, with no write and no retire count.
REQ-028 SHALL increment retire_cnt by 1 on each edge that captures a nonzero Instr_M (en=1, flush=0, reset=0).
REQ-029 SHALL wrap retire_cnt from 0xFFFFFFFF to 0.
REQ-030 SHALL NOT increment retire_cnt on stall, flush, reset or bubble capture.

Reset
REQ-031 SHALL, on reset, clear all pipeline registers and retire_cnt to 0, so that Instr_W=0, RegWrite_W=0, RegAddr_W=0, RegData_W=0 and retire_cnt=0 from the next cycle.
REQ-032 SHALL let reset asserted mid-stall or mid-flush override both, and SHALL let reset on the same edge as a capture discard the capture.

Structure
REQ-033 SHALL place opcode and funct constants, and the write-source enumeration (NONE/ALU/MEM/PC8/HILO), in a shared package used by all stage modules.
REQ-034 SHALL implement decode in one combinational sub-module, wb_decode (Instr -> write source, destination address); the pipeline registers and counter live in mem_wb_stage.

Verification
REQ-035 SHALL cover: addu $3,$1,$2 (0x00221821) with ALUResult_M=0x5 -> next cycle RegWrite_W=1, RegAddr_W=3, RegData_W=0x5, retire_cnt=1.
REQ-036 SHALL cover: lw $8,0($0) with DM_data_M=0xDEADBEEF and ALUResult_M=0x0 -> RegAddr_W=8, RegData_W=0xDEADBEEF.
REQ-037 SHALL cover: jal with pc_add_8_M=0x3008 -> RegAddr_W=31, RegData_W=0x3008; sw -> RegWrite_W=0.
REQ-038 SHALL cover: ori $0,$0,1 -> RegWrite_W=0, RegAddr_W=0, RegData_W=0, retire_cnt increments.
REQ-039 SHALL cover: en=0 for 3 cycles while inputs change -> W outputs and retire_cnt held; flush=1 with en=0 -> Instr_W=0, count unchanged.
REQ-040 SHALL cover: preload retire_cnt to 0xFFFFFFFF and retire one instruction -> 0; reset asserted together with en=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared decode constants and write-back source encoding for the MEM/WB pipeline stages.
// Only the opcodes/functs that produce a register write are named; everything else falls to "no write".
package mem_wb_stage_pkg;

    typedef enum logic [2:0] {
        WB_NONE = 3'd0,
        WB_ALU  = 3'd1,
        WB_MEM  = 3'd2,
        WB_PC8  = 3'd3,
        WB_HILO = 3'd4
    } wb_src_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/wb_decode.sv
// Write-back decode: instruction -> write source and raw destination register.
// Purely combinational; unknown opcodes/functs decode to WB_NONE.
module wb_decode
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    output wb_src_e     src_o,
    output logic [4:0]  dst_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op = instr_i[31:26];
    assign fn = instr_i[5:0];
    assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

    always_comb begin
        src_o = WB_NONE;
        dst_o = 5'd0;
        case (op)
            OP_SPECIAL: begin
                dst_o = instr_i[15:11];
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: src_o = WB_ALU;
                    FN_JALR:          src_o = WB_PC8;
                    FN_MFHI, FN_MFLO: src_o = WB_HILO;
                    default:          src_o = WB_NONE;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                src_o = WB_ALU;
                dst_o = instr_i[20:16];
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                src_o = WB_MEM;
                dst_o = instr_i[20:16];
            end
            OP_JAL: begin
                src_o = WB_PC8;
                dst_o = REG_RA;
            end
            default: begin
                src_o = WB_NONE;
                dst_o = 5'd0;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux and retire counter; latency 1 cycle.
// en=0 stalls (holds everything); flush loads a bubble; reset > flush > en.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] Instr_M,
    input  logic [31:0] pc_add_8_M,
    input  logic [31:0] ALUResult_M,
    input  logic [31:0] DM_data_M,
    input  logic [31:0] HiLo_M,
    output logic [31:0] Instr_W,
    output logic        RegWrite_W,
    output logic [4:0]  RegAddr_W,
    output logic [31:0] RegData_W,
    output logic [31:0] retire_cnt
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc8_q, pc8_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] dm_q, dm_d;
    logic [31:0] hilo_q, hilo_d;
    logic [31:0] retire_q, retire_d;

    always_comb begin
        instr_d  = instr_q;
        pc8_d    = pc8_q;
        alu_d    = alu_q;
        dm_d     = dm_q;
        hilo_d   = hilo_q;
        retire_d = retire_q;
        if (flush) begin
            instr_d = '0;
            pc8_d   = '0;
            alu_d   = '0;
            dm_d    = '0;
            hilo_d  = '0;
        end else if (en) begin
            instr_d = Instr_M;
            pc8_d   = pc_add_8_M;
            alu_d   = ALUResult_M;
            dm_d    = DM_data_M;
            hilo_d  = HiLo_M;
            // An all-zero word is the canonical nop (sll $0,$0,0) and does not retire.
            if (Instr_M != 32'd0) begin
                retire_d = retire_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q  <= '0;
            pc8_q    <= '0;
            alu_q    <= '0;
            dm_q     <= '0;
            hilo_q   <= '0;
            retire_q <= '0;
        end else begin
            instr_q  <= instr_d;
            pc8_q    <= pc8_d;
            alu_q    <= alu_d;
            dm_q     <= dm_d;
            hilo_q   <= hilo_d;
            retire_q <= retire_d;
        end
    end

    wb_src_e     src;
    logic [4:0]  dst;
    logic        wr;
    logic [31:0] data_sel;

    wb_decode u_decode (
        .instr_i (instr_q),
        .src_o   (src),
        .dst_o   (dst)
    );

    // Writes to $0 are suppressed so the forwarding path never sees a bogus producer.
    assign wr = (src != WB_NONE) && (dst != 5'd0);

    always_comb begin
        data_sel = '0;
        case (src)
            WB_ALU:  data_sel = alu_q;
            WB_MEM:  data_sel = dm_q;
            WB_PC8:  data_sel = pc8_q;
            WB_HILO: data_sel = hilo_q;
            default: data_sel = '0;
        endcase
    end

    assign Instr_W    = instr_q;
    assign RegWrite_W = wr;
    assign RegAddr_W  = wr ? dst : 5'd0;
    assign RegData_W  = wr ? data_sel : 32'd0;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized checks of mem_wb_stage against a behavioural reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, en, flush;
    logic [31:0] Instr_M, pc_add_8_M, ALUResult_M, DM_data_M, HiLo_M;
    logic [31:0] Instr_W, RegData_W, retire_cnt;
    logic        RegWrite_W;
    logic [4:0]  RegAddr_W;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .flush       (flush),
        .Instr_M     (Instr_M),
        .pc_add_8_M  (pc_add_8_M),
        .ALUResult_M (ALUResult_M),
        .DM_data_M   (DM_data_M),
        .HiLo_M      (HiLo_M),
        .Instr_W     (Instr_W),
        .RegWrite_W  (RegWrite_W),
        .RegAddr_W   (RegAddr_W),
        .RegData_W   (RegData_W),
        .retire_cnt  (retire_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model state: what the stage should be holding after each edge.
    logic [31:0] m_instr, m_pc8, m_alu, m_dm, m_hilo, m_cnt;

    function automatic void ref_wb(input logic [31:0] ins, pc8, alu, dm, hilo,
                                   output logic wr, output logic [4:0] a, output logic [31:0] d);
        int    op, fn, dest;
        string kind;
        op   = int'(ins[31:26]);
        fn   = int'(ins[5:0]);
        kind = "none";
        dest = 0;
        if (op == 0) begin
            dest = int'(ins[15:11]);
            if (fn inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43}) kind = "alu";
            else if (fn == 9)                                 kind = "pc8";
            else if (fn == 16 || fn == 18)                    kind = "hilo";
        end else if (op inside {[8:15]}) begin
            kind = "alu";
            dest = int'(ins[20:16]);
        end else if (op inside {32, 33, 35, 36, 37}) begin
            kind = "mem";
            dest = int'(ins[20:16]);
        end else if (op == 3) begin
            kind = "pc8";
            dest = 31;
        end
        wr = (kind != "none") && (dest != 0);
        a  = wr ? dest[4:0] : 5'd0;
        if (!wr)                d = 32'd0;
        else if (kind == "alu") d = alu;
        else if (kind == "mem") d = dm;
        else if (kind == "pc8") d = pc8;
        else                    d = hilo;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        ref_wb(m_instr, m_pc8, m_alu, m_dm, m_hilo, ew, ea, ed);
        chk({tag, ".Instr_W"},    Instr_W,             m_instr);
        chk({tag, ".RegWrite_W"}, {31'd0, RegWrite_W}, {31'd0, ew});
        chk({tag, ".RegAddr_W"},  {27'd0, RegAddr_W},  {27'd0, ea});
        chk({tag, ".RegData_W"},  RegData_W,           ed);
        chk({tag, ".retire_cnt"}, retire_cnt,          m_cnt);
    endtask

    task automatic set_data(input logic [31:0] ins, pc8, alu, dm, hilo);
        Instr_M     = ins;
        pc_add_8_M  = pc8;
        ALUResult_M = alu;
        DM_data_M   = dm;
        HiLo_M      = hilo;
    endtask

    // One clock: controls applied at the falling edge, model advanced at the rising edge, checked 1 later.
    task automatic step(input logic r, input logic e, input logic f, input string tag);
        @(negedge clk);
        reset = r;
        en    = e;
        flush = f;
        @(posedge clk);
        if (r) begin
            {m_instr, m_pc8, m_alu, m_dm, m_hilo, m_cnt} = '0;
        end else if (f) begin
            {m_instr, m_pc8, m_alu, m_dm, m_hilo} = '0;
        end else if (e) begin
            m_instr = Instr_M;
            m_pc8   = pc_add_8_M;
            m_alu   = ALUResult_M;
            m_dm    = DM_data_M;
            m_hilo  = HiLo_M;
            if (Instr_M != 32'd0) m_cnt = m_cnt + 32'd1;
        end
        #1;
        check_all(tag);
    endtask

    int unsigned ops [30] = '{0, 0, 0, 0, 0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13,
                              14, 15, 32, 33, 35, 36, 37, 40, 41, 43, 1, 6, 7, 16, 63};

    initial begin
        logic [31:0] held_cnt, held_data, rnd;
        {m_instr, m_pc8, m_alu, m_dm, m_hilo, m_cnt} = '0;
        reset = 1'b1;
        en    = 1'b0;
        flush = 1'b0;
        set_data(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        step(1, 0, 0, "reset0");
        step(1, 1, 0, "reset1");
        chk("reset.RegWrite_W", {31'd0, RegWrite_W}, 32'd0);
        chk("reset.retire_cnt", retire_cnt, 32'd0);

        set_data(32'h0022_1821, 32'h1111, 32'h5, 32'h2222, 32'h3333);
        step(0, 1, 0, "addu");
        chk("addu.RegWrite_W", {31'd0, RegWrite_W}, 32'd1);
        chk("addu.RegAddr_W",  {27'd0, RegAddr_W},  32'd3);
        chk("addu.RegData_W",  RegData_W,           32'h5);
        chk("addu.retire_cnt", retire_cnt,          32'd1);

        set_data(32'h8C08_0000, 32'h1111, 32'h0, 32'hDEAD_BEEF, 32'h3333);
        step(0, 1, 0, "lw");
        chk("lw.RegAddr_W", {27'd0, RegAddr_W}, 32'd8);
        chk("lw.RegData_W", RegData_W, 32'hDEAD_BEEF);

        set_data(32'h0C00_0C02, 32'h3008, 32'h44, 32'h55, 32'h66);
        step(0, 1, 0, "jal");
        chk("jal.RegAddr_W", {27'd0, RegAddr_W}, 32'd31);
        chk("jal.RegData_W", RegData_W, 32'h3008);

        set_data(32'hAC45_0004, 32'h77, 32'h88, 32'h99, 32'hAA);
        step(0, 1, 0, "sw");
        chk("sw.RegWrite_W", {31'd0, RegWrite_W}, 32'd0);

        set_data(32'h3400_0001, 32'h77, 32'h1, 32'h99, 32'hAA);
        step(0, 1, 0, "ori0");
        chk("ori0.RegWrite_W", {31'd0, RegWrite_W}, 32'd0);
        chk("ori0.RegAddr_W",  {27'd0, RegAddr_W},  32'd0);
        chk("ori0.RegData_W",  RegData_W,           32'd0);
        chk("ori0.retire_cnt", retire_cnt,          32'd5);

        set_data(32'h0000_2010, 32'h1, 32'h2, 32'h3, 32'hCAFE_F00D);
        step(0, 1, 0, "mfhi");
        chk("mfhi.RegData_W", RegData_W, 32'hCAFE_F00D);

        set_data(32'd0, 32'h1, 32'h2, 32'h3, 32'h4);
        step(0, 1, 0, "nop");
        chk("nop.retire_cnt", retire_cnt, 32'd6);

        set_data(32'h0043_2025, 32'h10, 32'hABCD_0123, 32'h30, 32'h40);
        step(0, 1, 0, "or");
        held_cnt  = retire_cnt;
        held_data = RegData_W;
        for (int i = 0; i < 3; i++) begin
            set_data($urandom, $urandom, $urandom, $urandom, $urandom);
            step(0, 0, 0, "stall");
            chk("stall.RegData_W",  RegData_W,  held_data);
            chk("stall.retire_cnt", retire_cnt, held_cnt);
        end
        step(0, 0, 1, "flush_noen");
        chk("flush.Instr_W",    Instr_W,    32'd0);
        chk("flush.retire_cnt", retire_cnt, held_cnt);
        set_data(32'h0022_1821, 32'h1, 32'h2, 32'h3, 32'h4);
        step(0, 1, 1, "flush_en");

        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            rnd[31:26] = 6'(ops[$urandom_range(0, 29)]);
            if ($urandom_range(0, 15) == 0) rnd = 32'd0;
            set_data(rnd, $urandom, $urandom, $urandom, $urandom);
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 11) == 0), "random");
        end

        @(negedge clk);
        dut.retire_q <= 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        chk("preload.retire_cnt", retire_cnt, 32'hFFFF_FFFF);
        set_data(32'h0022_1821, 32'h0, 32'h9, 32'h0, 32'h0);
        step(0, 1, 0, "wrap");
        chk("wrap.retire_cnt", retire_cnt, 32'd0);
        step(0, 1, 0, "wrap_next");
        chk("wrap_next.retire_cnt", retire_cnt, 32'd1);

        set_data(32'h8C08_0000, 32'h5, 32'h6, 32'h7, 32'h8);
        step(1, 1, 0, "reset_cap");
        chk("reset_cap.Instr_W",    Instr_W,             32'd0);
        chk("reset_cap.RegWrite_W", {31'd0, RegWrite_W}, 32'd0);
        chk("reset_cap.RegAddr_W",  {27'd0, RegAddr_W},  32'd0);
        chk("reset_cap.RegData_W",  RegData_W,           32'd0);
        chk("reset_cap.retire_cnt", retire_cnt,          32'd0);

        step(0, 1, 0, "after_reset");
        step(1, 0, 1, "reset_flush");
        chk("reset_flush.retire_cnt", retire_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
